// File: rtl/wdg_pkg.sv
// Shared definitions for the watchdog reset generator: FSM encoding and cause-bit positions.
package wdg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRE     = 2'd1,
        ST_ASSERT  = 2'd2,
        ST_HOLDOFF = 2'd3
    } wdg_state_e;

    localparam int CAUSE_S1 = 0;
    localparam int CAUSE_S2 = 1;

endpackage

// File: rtl/wdg_edge_det.sv
// One-bit input register with a rising-edge strobe derived from the registered copy.
module wdg_edge_det (
    input  logic clk,
    input  logic res,
    input  logic d_i,
    output logic q_o,
    output logic rise_o
);

    logic d_q;

    always_ff @(posedge clk or posedge res) begin
        if (res) d_q <= 1'b0;
        else     d_q <= d_i;
    end

    assign q_o    = d_q;
    assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/wdg_rst_gen.sv
// Turns watchdog stage-1/stage-2 timeouts into a CPU interrupt and a delayed, fixed-length
// system reset request, with a sticky cause record and a saturating reset counter.
module wdg_rst_gen
    import wdg_pkg::*;
#(
    parameter int PRE_RST_DELAY    = 4,
    parameter int RST_PULSE_CYCLES = 16,
    parameter int CNT_WIDTH        = 8,
    parameter int RST_CNT_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic                     i_irq1,
    input  logic                     i_irq2,
    input  logic                     i_cause_clr,
    output logic                     o_cpu_irq,
    output logic                     o_pre_warn,
    output logic                     o_sys_rst,
    output logic                     o_busy,
    output logic [1:0]               o_rst_cause,
    output logic [RST_CNT_WIDTH-1:0] o_rst_cnt
);

    wdg_state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
    logic [1:0]               cause_q, cause_d;
    logic [RST_CNT_WIDTH-1:0] rst_cnt_q, rst_cnt_d;
    logic                     pre_warn_q, sys_rst_q, busy_q;
    logic                     irq2_q, irq2_rise;
    logic                     irq1_rise_unused;
    logic                     rst_entry;

    wdg_edge_det u_irq1 (
        .clk    (clk),
        .res    (res),
        .d_i    (i_irq1),
        .q_o    (o_cpu_irq),
        .rise_o (irq1_rise_unused)
    );

    wdg_edge_det u_irq2 (
        .clk    (clk),
        .res    (res),
        .d_i    (i_irq2),
        .q_o    (irq2_q),
        .rise_o (irq2_rise)
    );

    // Once PRE is entered the reset is committed; only HOLDOFF looks at i_irq2 again.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (irq2_rise) begin
                    if (PRE_RST_DELAY == 0) begin
                        state_d = ST_ASSERT;
                        cnt_d   = CNT_WIDTH'(RST_PULSE_CYCLES);
                    end else begin
                        state_d = ST_PRE;
                        cnt_d   = CNT_WIDTH'(PRE_RST_DELAY);
                    end
                end
            end
            ST_PRE: begin
                if (cnt_q <= CNT_WIDTH'(1)) begin
                    state_d = ST_ASSERT;
                    cnt_d   = CNT_WIDTH'(RST_PULSE_CYCLES);
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            ST_ASSERT: begin
                if (cnt_q <= CNT_WIDTH'(1)) state_d = ST_HOLDOFF;
                else                        cnt_d   = cnt_q - CNT_WIDTH'(1);
            end
            ST_HOLDOFF: begin
                if (!i_irq2) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rst_entry = (state_d == ST_ASSERT) && (state_q != ST_ASSERT);

    // Set beats clear when both happen in the same cycle.
    always_comb begin
        cause_d           = cause_q & ~{2{i_cause_clr}};
        cause_d[CAUSE_S1] = cause_d[CAUSE_S1] | i_irq1;
        cause_d[CAUSE_S2] = cause_d[CAUSE_S2] | rst_entry;
        rst_cnt_d         = rst_cnt_q;
        if (rst_entry && !(&rst_cnt_q)) rst_cnt_d = rst_cnt_q + RST_CNT_WIDTH'(1);
    end

    // Outputs come straight from flops so o_sys_rst cannot glitch on state decode.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cause_q    <= '0;
            rst_cnt_q  <= '0;
            pre_warn_q <= 1'b0;
            sys_rst_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cause_q    <= cause_d;
            rst_cnt_q  <= rst_cnt_d;
            pre_warn_q <= (state_d == ST_PRE);
            sys_rst_q  <= (state_d == ST_ASSERT);
            busy_q     <= (state_d != ST_IDLE);
        end
    end

    assign o_pre_warn  = pre_warn_q;
    assign o_sys_rst   = sys_rst_q;
    assign o_busy      = busy_q;
    assign o_rst_cause = cause_q;
    assign o_rst_cnt   = rst_cnt_q;

endmodule

// File: tb/tb_wdg_rst_gen.sv
// Directed checks of wdg_rst_gen across three parameter sets sharing one clock and reset.
module tb_wdg_rst_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       res;
    logic [2:0] irq1, irq2, clr;

    logic       cpu  [3];
    logic       pw   [3];
    logic       sr   [3];
    logic       busy [3];
    logic [1:0] cause[3];
    logic [7:0] cnt0, cnt1;
    logic [1:0] cnt2;

    int n_run  = 0;
    int n_fail = 0;

    wdg_rst_gen u0 (
        .clk(clk), .res(res), .i_irq1(irq1[0]), .i_irq2(irq2[0]), .i_cause_clr(clr[0]),
        .o_cpu_irq(cpu[0]), .o_pre_warn(pw[0]), .o_sys_rst(sr[0]), .o_busy(busy[0]),
        .o_rst_cause(cause[0]), .o_rst_cnt(cnt0)
    );

    wdg_rst_gen #(.PRE_RST_DELAY(0)) u1 (
        .clk(clk), .res(res), .i_irq1(irq1[1]), .i_irq2(irq2[1]), .i_cause_clr(clr[1]),
        .o_cpu_irq(cpu[1]), .o_pre_warn(pw[1]), .o_sys_rst(sr[1]), .o_busy(busy[1]),
        .o_rst_cause(cause[1]), .o_rst_cnt(cnt1)
    );

    wdg_rst_gen #(.PRE_RST_DELAY(1), .RST_PULSE_CYCLES(2), .RST_CNT_WIDTH(2)) u2 (
        .clk(clk), .res(res), .i_irq1(irq1[2]), .i_irq2(irq2[2]), .i_cause_clr(clr[2]),
        .o_cpu_irq(cpu[2]), .o_pre_warn(pw[2]), .o_sys_rst(sr[2]), .o_busy(busy[2]),
        .o_rst_cause(cause[2]), .o_rst_cnt(cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic pw_log[0:23];
    logic sr_log[0:23];
    int   pw_n, sr_n;
    logic pw_any;

    initial begin
        res  = 1'b1;
        irq1 = '0;
        irq2 = '0;
        clr  = '0;
        repeat (3) @(posedge clk);
        #1 res = 1'b0;

        @(negedge clk);
        chk("rst_cpu_irq",  32'(cpu[0]),   0);
        chk("rst_pre_warn", 32'(pw[0]),    0);
        chk("rst_sys_rst",  32'(sr[0]),    0);
        chk("rst_busy",     32'(busy[0]),  0);
        chk("rst_cause",    32'(cause[0]), 0);
        chk("rst_cnt",      32'(cnt0),     0);

        // Defaults: i_irq2 high from t=0; PRE t=1..4, ASSERT t=5..20.
        tick();
        irq2[0] = 1'b1;
        pw_n = 0;
        sr_n = 0;
        for (int t = 0; t < 24; t++) begin
            @(negedge clk);
            pw_log[t] = pw[0];
            sr_log[t] = sr[0];
            pw_n += int'(pw[0]);
            sr_n += int'(sr[0]);
            if (t < 23) tick();
        end
        chk("pw_t0",    32'(pw_log[0]),  0);
        chk("pw_t1",    32'(pw_log[1]),  1);
        chk("pw_t4",    32'(pw_log[4]),  1);
        chk("pw_t5",    32'(pw_log[5]),  0);
        chk("pw_len",   32'(pw_n),       4);
        chk("sr_t4",    32'(sr_log[4]),  0);
        chk("sr_t5",    32'(sr_log[5]),  1);
        chk("sr_t20",   32'(sr_log[20]), 1);
        chk("sr_t21",   32'(sr_log[21]), 0);
        chk("sr_len",   32'(sr_n),       16);
        chk("cause_s2", 32'(cause[0]),   2);
        chk("cnt_1",    32'(cnt0),       1);
        chk("holdoff_busy", 32'(busy[0]), 1);

        // Drop i_irq2: one more HOLDOFF cycle, then IDLE; a new rise gives a second reset.
        tick();
        irq2[0] = 1'b0;
        tick();
        @(negedge clk);
        chk("idle_after_drop", 32'(busy[0]), 0);
        tick();
        irq2[0] = 1'b1;
        repeat (25) tick();
        @(negedge clk);
        chk("cnt_2",       32'(cnt0),     2);
        chk("cause_again", 32'(cause[0]), 2);
        tick();
        irq2[0] = 1'b0;
        repeat (3) tick();

        // Cause clear, stage-1 forwarding, set-wins-over-clear.
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        @(negedge clk);
        chk("cause_clr", 32'(cause[0]), 0);
        tick();
        irq1[0] = 1'b1;
        @(negedge clk);
        chk("cpu_irq_lag0", 32'(cpu[0]), 0);
        tick();
        irq1[0] = 1'b0;
        @(negedge clk);
        chk("cpu_irq_lag1", 32'(cpu[0]),   1);
        chk("cause_s1",     32'(cause[0]), 1);
        tick();
        irq1[0] = 1'b1;
        clr[0]  = 1'b1;
        @(negedge clk);
        chk("cpu_irq_fall", 32'(cpu[0]), 0);
        tick();
        irq1[0] = 1'b0;
        clr[0]  = 1'b0;
        @(negedge clk);
        chk("set_wins",     32'(cause[0]), 1);
        chk("cpu_irq_2nd",  32'(cpu[0]),   1);
        chk("cnt_kept",     32'(cnt0),     2);

        // PRE_RST_DELAY=0: reset pulse starts the cycle after the rise, no pre-warn.
        tick();
        irq2[1] = 1'b1;
        pw_any = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            sr_log[t] = sr[1];
            pw_any |= pw[1];
            if (t < 19) tick();
        end
        chk("d0_sr_t0",  32'(sr_log[0]),  0);
        chk("d0_sr_t1",  32'(sr_log[1]),  1);
        chk("d0_sr_t16", 32'(sr_log[16]), 1);
        chk("d0_sr_t17", 32'(sr_log[17]), 0);
        chk("d0_no_pw",  32'(pw_any),     0);
        tick();
        irq2[1] = 1'b0;

        // RST_CNT_WIDTH=2: counter saturates at 3.
        for (int k = 1; k <= 5; k++) begin
            tick();
            irq2[2] = 1'b1;
            repeat (6) tick();
            irq2[2] = 1'b0;
            repeat (2) tick();
            @(negedge clk);
            chk($sformatf("sat_cnt_%0d", k), 32'(cnt2), (k < 3) ? k : 3);
        end

        // Async reset in the middle of ASSERT.
        tick();
        irq2[0] = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        chk("pre_async_sr", 32'(sr[0]), 1);
        #2 res = 1'b1;
        #1;
        chk("async_sr",    32'(sr[0]),    0);
        chk("async_pw",    32'(pw[0]),    0);
        chk("async_busy",  32'(busy[0]),  0);
        chk("async_cause", 32'(cause[0]), 0);
        chk("async_cnt",   32'(cnt0),     0);
        chk("async_cpu",   32'(cpu[0]),   0);
        irq2[0] = 1'b0;
        tick();
        res = 1'b0;
        tick();
        @(negedge clk);
        chk("post_async_busy", 32'(busy[0]), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
